// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller.
// Holds the controller state encoding, the coin value constants and the
// default pricing/sizing parameters used by vend_ctrl.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC    = 3'd1,
    S_VEND   = 3'd2,
    S_CHANGE = 3'd3,
    S_FAULT  = 3'd4
  } vend_state_t;

  // Coin values in 10-unit steps
  localparam int COIN_A_VAL = 1;
  localparam int DEF_B_VAL  = 5;

  // Default sizing
  localparam int DEF_PRICE  = 5;
  localparam int DEF_CW     = 4;
  localparam int DEF_TMO    = 15;

endpackage

// File: rtl/vend_hs_timer.sv
// hs_timer: handshake watchdog, a TMO-cycle down-counter.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_clr        - reload the counter to TMO (handshake start / progress)
//   i_en         - count down while a handshake is outstanding
//   o_expired    - high in the cycle whose edge would bring the count to 0,
//                  i.e. the TMO-th consecutive enabled cycle without a clear
module hs_timer #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= TW'(TMO);
    else if (i_en && (r_cnt != '0))
      r_cnt <= r_cnt - TW'(1);
  end

  assign o_expired = i_en && (r_cnt == TW'(1));

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin accumulation, dispense handshake and one-coin-at-a-time
// change payout, with a watchdog on each actuator handshake.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   a, b                - 10-unit / B_VAL-unit coin pulses
//   ret                 - refund request pulse (honoured in ACC only)
//   disp_ack            - dispenser done pulse
//   pay_done            - hopper ejected one coin pulse
//   disp_req, pay_req   - actuator request levels (registered)
//   credit              - current credit in 10-unit steps
//   coin_rej            - registered reject pulse, cycle after the coin
//   busy                - high in VEND, CHANGE and FAULT
//   fault               - sticky handshake timeout, cleared only by rst
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE = DEF_PRICE,
  parameter int B_VAL = DEF_B_VAL,
  parameter int CW    = DEF_CW,
  parameter int TMO   = DEF_TMO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          b,
  input  logic          ret,
  input  logic          disp_ack,
  input  logic          pay_done,
  output logic          disp_req,
  output logic          pay_req,
  output logic [CW-1:0] credit,
  output logic          coin_rej,
  output logic          busy,
  output logic          fault
);

  localparam int CW1 = CW + 1;
  localparam logic [CW:0] MAX_CRED = {1'b0, {CW{1'b1}}};

  vend_state_t   r_state;
  logic [CW-1:0] r_credit;
  logic          r_disp_req;
  logic          r_pay_req;
  logic          r_coin_rej;
  logic          r_fault;

  logic          w_open;
  logic          w_accept;
  logic          w_rej;
  logic          w_go_refund;
  logic          w_go_vend;
  logic          w_tmr_en;
  logic          w_tmr_clr;
  logic          w_expired;
  logic [CW:0]   w_add;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_cred_in;
  logic [CW-1:0] w_cred_vend;

  always_comb begin
    w_open    = (r_state == S_IDLE) || (r_state == S_ACC);
    w_add     = a ? CW1'(COIN_A_VAL) : CW1'(B_VAL);
    // One extra bit so an overflowing sum is visible before truncation
    w_sum     = {1'b0, r_credit} + w_add;
    w_accept  = w_open && (a ^ b) && (w_sum <= MAX_CRED);
    w_rej     = (a || b) && !w_accept;
    w_cred_in = w_accept ? w_sum[CW-1:0] : r_credit;
    // A coin arriving with ret is credited first, then fully refunded
    w_go_refund = (r_state == S_ACC) && ret && (w_cred_in != '0);
    w_go_vend   = w_accept && !w_go_refund && (w_cred_in >= CW'(PRICE));
    w_cred_vend = r_credit - CW'(PRICE);
    w_tmr_en    = (r_state == S_VEND) || (r_state == S_CHANGE);
    w_tmr_clr   = w_go_refund || w_go_vend ||
                  ((r_state == S_VEND)   && disp_ack) ||
                  ((r_state == S_CHANGE) && pay_done);
  end

  hs_timer #(.TMO(TMO)) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_disp_req <= 1'b0;
      r_pay_req  <= 1'b0;
      r_coin_rej <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_coin_rej <= w_rej;
      unique case (r_state)
        S_IDLE, S_ACC: begin
          r_credit <= w_cred_in;
          if (w_go_refund) begin
            r_state   <= S_CHANGE;
            r_pay_req <= 1'b1;
          end else if (w_go_vend) begin
            r_state    <= S_VEND;
            r_disp_req <= 1'b1;
          end else if (w_accept) begin
            r_state <= S_ACC;
          end
        end
        S_VEND: begin
          if (disp_ack) begin
            r_credit   <= w_cred_vend;
            r_disp_req <= 1'b0;
            if (w_cred_vend != '0) begin
              r_state   <= S_CHANGE;
              r_pay_req <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_expired) begin
            r_state    <= S_FAULT;
            r_disp_req <= 1'b0;
            r_fault    <= 1'b1;
          end
        end
        S_CHANGE: begin
          if (pay_done) begin
            r_credit <= r_credit - CW'(1);
            // Last coin: request drops on the same edge credit hits 0
            if (r_credit == CW'(1)) begin
              r_state   <= S_IDLE;
              r_pay_req <= 1'b0;
            end
          end else if (w_expired) begin
            r_state   <= S_FAULT;
            r_pay_req <= 1'b0;
            r_fault   <= 1'b1;
          end
        end
        default: begin
          // FAULT: everything frozen until rst
        end
      endcase
    end
  end

  assign disp_req = r_disp_req;
  assign pay_req  = r_pay_req;
  assign credit   = r_credit;
  assign coin_rej = r_coin_rej;
  assign fault    = r_fault;
  assign busy     = (r_state == S_VEND) || (r_state == S_CHANGE) ||
                    (r_state == S_FAULT);

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default pricing)
  logic       rst, a, b, ret, disp_ack, pay_done;
  logic       disp_req, pay_req, coin_rej, busy, fault;
  logic [3:0] credit;

  // Saturation instance: PRICE=15 so credit can sit near 2^CW-1 in ACC
  logic       rst2, a2, b2, ret2, ack2, done2;
  logic       dreq2, preq2, rej2, busy2, fault2;
  logic [3:0] credit2;

  vend_ctrl #(.PRICE(5), .B_VAL(5), .CW(4), .TMO(15)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ret(ret),
    .disp_ack(disp_ack), .pay_done(pay_done),
    .disp_req(disp_req), .pay_req(pay_req), .credit(credit),
    .coin_rej(coin_rej), .busy(busy), .fault(fault)
  );

  vend_ctrl #(.PRICE(15), .B_VAL(5), .CW(4), .TMO(15)) dut_sat (
    .clk(clk), .rst(rst2), .a(a2), .b(b2), .ret(ret2),
    .disp_ack(ack2), .pay_done(done2),
    .disp_req(dreq2), .pay_req(preq2), .credit(credit2),
    .coin_rej(rej2), .busy(busy2), .fault(fault2)
  );

  // Stimulus codes {rst,a,b,ret,ack,done}
  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_RST  = 6'b100000;
  localparam logic [5:0] ST_A    = 6'b010000;
  localparam logic [5:0] ST_B    = 6'b001000;
  localparam logic [5:0] ST_RET  = 6'b000100;
  localparam logic [5:0] ST_ACK  = 6'b000010;
  localparam logic [5:0] ST_DONE = 6'b000001;

  typedef struct packed {
    logic [3:0] cr;
    logic       dreq;
    logic       preq;
    logic       rej;
    logic       bsy;
    logic       flt;
  } exp_t;

  exp_t       sbq[$];     // scoreboard: expected outputs in flight
  logic [5:0] st_q[$];    // planned stimulus
  exp_t       pl_q[$];    // planned expectation per stimulus
  int         n_chk  = 0;
  int         n_fail = 0;

  function automatic exp_t ex(input int cr, input bit dq, input bit pq,
                              input bit rj, input bit bs, input bit ft);
    exp_t e;
    e.cr = 4'(cr); e.dreq = dq; e.preq = pq; e.rej = rj; e.bsy = bs; e.flt = ft;
    return e;
  endfunction

  function automatic void row(input logic [5:0] s, input exp_t e);
    st_q.push_back(s);
    pl_q.push_back(e);
  endfunction

  task automatic drive(input logic [5:0] s);
    {rst, a, b, ret, disp_ack, pay_done} = s;
    @(posedge clk); #1;
    {rst, a, b, ret, disp_ack, pay_done} = '0;
  endtask

  task automatic drive2(input logic [5:0] s);
    {rst2, a2, b2, ret2, ack2, done2} = s;
    @(posedge clk); #1;
    {rst2, a2, b2, ret2, ack2, done2} = '0;
  endtask

  task automatic test_reset();
    exp_t got, want;
    int k = 0;
    row(ST_RST | ST_A, ex(0,0,0,0,0,0));
    row(ST_RST,        ex(0,0,0,0,0,0));
    row(ST_NONE,       ex(0,0,0,0,0,0));
    // mid-transaction resets: pending CHANGE and pending VEND
    row(ST_A,          ex(1,0,0,0,0,0));
    row(ST_RET,        ex(1,0,1,0,1,0));
    row(ST_RST,        ex(0,0,0,0,0,0));
    row(ST_B,          ex(5,1,0,0,1,0));
    row(ST_RST,        ex(0,0,0,0,0,0));
    while (st_q.size() > 0) begin
      sbq.push_back(pl_q.pop_front());
      drive(st_q.pop_front());
      got  = {credit, disp_req, pay_req, coin_rej, busy, fault};
      want = sbq.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset step %0d: credit %0d flags %b, required credit %0d flags %b (dreq,preq,rej,busy,fault)",
                 k, got.cr, got[4:0], want.cr, want[4:0]);
      end
      k++;
    end
  endtask

  task automatic test_exact_vend();
    exp_t got, want;
    int k = 0;
    for (int i = 1; i <= 4; i++) row(ST_A, ex(i,0,0,0,0,0));
    row(ST_A,    ex(5,1,0,0,1,0));
    row(ST_NONE, ex(5,1,0,0,1,0));
    row(ST_NONE, ex(5,1,0,0,1,0));
    row(ST_ACK,  ex(0,0,0,0,0,0));
    row(ST_NONE, ex(0,0,0,0,0,0));
    while (st_q.size() > 0) begin
      sbq.push_back(pl_q.pop_front());
      drive(st_q.pop_front());
      got  = {credit, disp_req, pay_req, coin_rej, busy, fault};
      want = sbq.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL exact_vend step %0d: credit %0d flags %b, required credit %0d flags %b",
                 k, got.cr, got[4:0], want.cr, want[4:0]);
      end
      k++;
    end
  endtask

  task automatic test_change();
    exp_t got, want;
    int k = 0;
    row(ST_A,    ex(1,0,0,0,0,0));
    row(ST_B,    ex(6,1,0,0,1,0));
    row(ST_ACK,  ex(1,0,1,0,1,0));
    row(ST_DONE, ex(0,0,0,0,0,0));
    row(ST_NONE, ex(0,0,0,0,0,0));
    while (st_q.size() > 0) begin
      sbq.push_back(pl_q.pop_front());
      drive(st_q.pop_front());
      got  = {credit, disp_req, pay_req, coin_rej, busy, fault};
      want = sbq.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL change step %0d: credit %0d flags %b, required credit %0d flags %b",
                 k, got.cr, got[4:0], want.cr, want[4:0]);
      end
      k++;
    end
  endtask

  task automatic test_refund();
    exp_t got, want;
    int k = 0;
    for (int i = 1; i <= 3; i++) row(ST_A, ex(i,0,0,0,0,0));
    row(ST_RET,  ex(3,0,1,0,1,0));
    row(ST_DONE, ex(2,0,1,0,1,0));
    row(ST_DONE, ex(1,0,1,0,1,0));
    row(ST_DONE, ex(0,0,0,0,0,0));
    row(ST_RET,  ex(0,0,0,0,0,0));   // ignored in IDLE
    row(ST_DONE, ex(0,0,0,0,0,0));   // ignored outside CHANGE
    while (st_q.size() > 0) begin
      sbq.push_back(pl_q.pop_front());
      drive(st_q.pop_front());
      got  = {credit, disp_req, pay_req, coin_rej, busy, fault};
      want = sbq.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL refund step %0d: credit %0d flags %b, required credit %0d flags %b",
                 k, got.cr, got[4:0], want.cr, want[4:0]);
      end
      k++;
    end
  endtask

  task automatic test_reject();
    exp_t got, want;
    int k = 0;
    row(ST_A | ST_B,     ex(0,0,0,1,0,0));
    row(ST_NONE,         ex(0,0,0,0,0,0));
    row(ST_B,            ex(5,1,0,0,1,0));
    row(ST_B,            ex(5,1,0,1,1,0));
    row(ST_A,            ex(5,1,0,1,1,0));
    row(ST_ACK,          ex(0,0,0,0,0,0));
    row(ST_ACK | ST_DONE,ex(0,0,0,0,0,0));
    row(ST_A,            ex(1,0,0,0,0,0));
    row(ST_A | ST_B,     ex(1,0,0,1,0,0));
    row(ST_RET,          ex(1,0,1,0,1,0));
    row(ST_DONE,         ex(0,0,0,0,0,0));
    while (st_q.size() > 0) begin
      sbq.push_back(pl_q.pop_front());
      drive(st_q.pop_front());
      got  = {credit, disp_req, pay_req, coin_rej, busy, fault};
      want = sbq.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reject step %0d: credit %0d flags %b, required credit %0d flags %b",
                 k, got.cr, got[4:0], want.cr, want[4:0]);
      end
      k++;
    end
  endtask

  // Coin + ret reaching PRICE refunds instead of vending; payout back-to-back
  task automatic test_back_to_back();
    exp_t got, want;
    int k = 0;
    for (int i = 1; i <= 4; i++) row(ST_A, ex(i,0,0,0,0,0));
    row(ST_A | ST_RET, ex(5,0,1,0,1,0));
    for (int i = 4; i >= 1; i--) row(ST_DONE, ex(i,0,1,0,1,0));
    row(ST_DONE, ex(0,0,0,0,0,0));
    while (st_q.size() > 0) begin
      sbq.push_back(pl_q.pop_front());
      drive(st_q.pop_front());
      got  = {credit, disp_req, pay_req, coin_rej, busy, fault};
      want = sbq.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: credit %0d flags %b, required credit %0d flags %b",
                 k, got.cr, got[4:0], want.cr, want[4:0]);
      end
      k++;
    end
  endtask

  task automatic test_timeout();
    exp_t got, want;
    int k = 0;
    // VEND watchdog
    row(ST_B, ex(5,1,0,0,1,0));
    for (int i = 0; i < 14; i++) row(ST_NONE, ex(5,1,0,0,1,0));
    row(ST_NONE, ex(5,0,0,0,1,1));
    row(ST_A,    ex(5,0,0,1,1,1));
    row(ST_ACK,  ex(5,0,0,0,1,1));
    row(ST_RET,  ex(5,0,0,0,1,1));
    row(ST_RST,  ex(0,0,0,0,0,0));
    row(ST_NONE, ex(0,0,0,0,0,0));
    // CHANGE watchdog, restarted by a pay_done
    row(ST_A,    ex(1,0,0,0,0,0));
    row(ST_A,    ex(2,0,0,0,0,0));
    row(ST_RET,  ex(2,0,1,0,1,0));
    for (int i = 0; i < 10; i++) row(ST_NONE, ex(2,0,1,0,1,0));
    row(ST_DONE, ex(1,0,1,0,1,0));
    for (int i = 0; i < 14; i++) row(ST_NONE, ex(1,0,1,0,1,0));
    row(ST_NONE, ex(1,0,0,0,1,1));
    row(ST_RST,  ex(0,0,0,0,0,0));
    while (st_q.size() > 0) begin
      sbq.push_back(pl_q.pop_front());
      drive(st_q.pop_front());
      got  = {credit, disp_req, pay_req, coin_rej, busy, fault};
      want = sbq.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL timeout step %0d: credit %0d flags %b, required credit %0d flags %b",
                 k, got.cr, got[4:0], want.cr, want[4:0]);
      end
      k++;
    end
  endtask

  task automatic test_saturation();
    exp_t got, want;
    int k = 0;
    row(ST_RST,  ex(0,0,0,0,0,0));
    row(ST_B,    ex(5,0,0,0,0,0));
    row(ST_B,    ex(10,0,0,0,0,0));
    row(ST_A,    ex(11,0,0,0,0,0));
    row(ST_A,    ex(12,0,0,0,0,0));
    row(ST_B,    ex(12,0,0,1,0,0));   // 17 > 15
    row(ST_A,    ex(13,0,0,0,0,0));
    row(ST_A,    ex(14,0,0,0,0,0));
    row(ST_B,    ex(14,0,0,1,0,0));   // 19 > 15
    row(ST_A,    ex(15,1,0,0,1,0));   // exactly 2^CW-1, reaches price
    row(ST_ACK,  ex(0,0,0,0,0,0));
    while (st_q.size() > 0) begin
      sbq.push_back(pl_q.pop_front());
      drive2(st_q.pop_front());
      got  = {credit2, dreq2, preq2, rej2, busy2, fault2};
      want = sbq.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL saturation step %0d: credit %0d flags %b, required credit %0d flags %b",
                 k, got.cr, got[4:0], want.cr, want[4:0]);
      end
      k++;
    end
  endtask

  initial begin
    {rst, a, b, ret, disp_ack, pay_done} = 6'b100000;
    {rst2, a2, b2, ret2, ack2, done2}    = 6'b100000;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_exact_vend();
    test_change();
    test_refund();
    test_reject();
    test_back_to_back();
    test_timeout();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Transaction controller for the vending datapath. It accepts 10-unit (`a`) and 50-unit (`b`) coin pulses and accumulates credit. Once the price is reached it drives a can dispenser through a request/acknowledge handshake, then pays change one 10-unit coin at a time through a hopper handshake. It sits between the coin mechanism and the dispenser/hopper actuators and replaces direct state-to-output decoding with a sequenced, timeout-protected controller.

## Interface
Parameters:
- `PRICE`, 5: can price in 10-unit steps.
- `B_VAL`, 5: value of a `b` coin in 10-unit steps.
- `CW`, 4: credit counter width; maximum credit is 2^CW-1.
- `TMO`, 15: cycles allowed per handshake before fault.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `a` in 1: 10-unit coin pulse, one cycle per coin.
- `b` in 1: 50-unit coin pulse, one cycle per coin.
- `ret` in 1: refund request pulse.
- `disp_ack` in 1: dispenser done, one-cycle pulse.
- `pay_done` in 1: hopper ejected one coin, one-cycle pulse.
- `disp_req` out 1: dispense request, level.
- `pay_req` out 1: change request, level.
- `credit` out CW: current credit in 10-unit steps.
- `coin_rej` out 1: coin rejected, one-cycle pulse.
- `busy` out 1: high in VEND, CHANGE and FAULT.
- `fault` out 1: handshake timeout, sticky.

## Operation
- States: IDLE, ACC, VEND, CHANGE, FAULT. Encodings live in the shared package.
- Coins are accepted only in IDLE and ACC.
  - Value: `a` adds 1, `b` adds B_VAL.
  - Rejected with a `coin_rej` pulse and no credit change when any of these hold:
    - `a` and `b` are high in the same cycle (both coins rejected).
    - The sum would exceed 2^CW-1.
    - The coin arrives in VEND, CHANGE or FAULT.
- IDLE→ACC on an accepted coin leaving credit < PRICE. IDLE/ACC→VEND on an accepted coin leaving credit ≥ PRICE.
- VEND:
  - `disp_req`=1.
  - On `disp_ack`, credit decrements by PRICE.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE:
  - `pay_req`=1 while credit > 0.
  - Each `pay_done` decrements credit by 1.
  - When credit reaches 0, next state is IDLE and `pay_req` drops in the same cycle.
- `ret` in ACC with credit > 0: →CHANGE (full refund). `ret` in any other state is ignored.
- If `ret` and an accepted coin occur in the same ACC cycle, the coin is added first, then the refund starts.
- Timeout counter:
  - Clears on entry to VEND/CHANGE and on every `disp_ack`/`pay_done`; increments otherwise in those states.
  - Reaching TMO→FAULT.
- FAULT:
  - `disp_req`=`pay_req`=0, `fault`=1, credit frozen.
  - Exits only on `rst`.
- `disp_ack` outside VEND and `pay_done` outside CHANGE are ignored.

## Timing
- Reset values: state IDLE, credit 0, all outputs 0, timeout counter 0.
- Reset mid-transaction drops any pending request on the next edge and discards credit.
- Coin sampled at edge N: credit and state update at edge N; `disp_req` is high in cycle N+1.
- `coin_rej` is registered and pulses in the cycle after the offending coin.
- `disp_req` and `pay_req` are Moore outputs. `disp_ack` at edge M: `disp_req` is low from cycle M+1, and `pay_req` is high from M+1 if change is due.
- Minimum change payout: one coin per cycle when `pay_done` is asserted back-to-back.
- Credit arithmetic is unsigned CW bits; the saturation check uses CW+1 bits.

## Structure
- Package `vend_pkg`: state enum `vend_state_t`, coin value constants, default PRICE/B_VAL.
- Sub-module `hs_timer`: TMO-cycle down-counter with clear/enable and an `expired` output, reusable for both handshakes.

## Test plan
- Five `a` pulses, `disp_ack` 3 cycles after `disp_req` rises → credit 0,1,2,3,4,5; `disp_req` for 3 cycles; no `pay_req`; back to IDLE, credit 0.
- One `a`, then `b` → credit 6, VEND; after `disp_ack`, credit 1, `pay_req` high; `pay_done` → credit 0, IDLE.
- Three `a` pulses, then `ret` → CHANGE; three `pay_done` pulses → credit 2,1,0; `pay_req` low after the third.
- `a` and `b` together in IDLE → `coin_rej` pulse, credit stays 0. `b` during VEND → `coin_rej`, credit unchanged.
- Credit 14 (CW=4): `b` → rejected, credit stays 14. Credit 12: `b` would reach 17 > 15 → rejected.
- No `disp_ack` for 15 cycles in VEND → FAULT, `fault`=1, `disp_req`=0, coins rejected; `rst` → IDLE, all outputs 0.
